// File: rtl/riscv_v_writeback_element.sv
// -----------------------------------------------------------------------------
// riscv_v_writeback_element
//
// Vector writeback element. It takes one ALU result per register and builds
// per-byte write enables from the element size, vl and vstart. It queues the
// result in a 2-entry FIFO and presents it to the vector register file write
// port through a valid/ready handshake. It also publishes a scoreboard of
// destination registers that still have a buffered write, so issue logic can
// stall on RAW hazards.
//
// Optional feature macro: RISCV_V_WB_BYPASS_EN
//   When defined, a result arriving at an empty buffer is forwarded to the
//   write port combinationally in the same cycle. It is only stored if the VRF
//   does not take it in that cycle.
//   When undefined, results always reach the write port one cycle after they
//   are accepted.
//
// Parameters
//   DATA_W     vector register width in bits
//   NUM_BYTES  bytes per register (byte-enable width)
//   LEN_W      width of len / vstart (range 0..NUM_BYTES)
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     ALU result valid
//   in_ready     writeback can accept (buffer not full)
//   in_data      result data
//   in_vd        destination register index
//   in_osize     element size: 0=8b .. 4=128b, 5..7 illegal
//   in_len       vl in elements
//   in_vstart    first element to write
//   flush        synchronous discard of all buffered entries
//   wr_valid     VRF write request
//   wr_ready     VRF accepts the write
//   wr_vd        VRF write index
//   wr_data      VRF write data
//   wr_be        VRF byte enables
//   pending_vd   bit k set while a buffered entry targets vk
//   err_osize    one-cycle pulse after an accepted illegal osize
// -----------------------------------------------------------------------------
module riscv_v_writeback_element #(
    parameter int DATA_W    = 128,
    parameter int NUM_BYTES = DATA_W / 8,
    parameter int LEN_W     = $clog2(NUM_BYTES) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [4:0]           in_vd,
    input  logic [2:0]           in_osize,
    input  logic [LEN_W-1:0]     in_len,
    input  logic [LEN_W-1:0]     in_vstart,
    input  logic                 flush,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [4:0]           wr_vd,
    output logic [DATA_W-1:0]    wr_data,
    output logic [NUM_BYTES-1:0] wr_be,
    output logic [31:0]          pending_vd,
    output logic                 err_osize
);

    // FIFO storage: data fields are not reset; validity comes from the count.
    logic [DATA_W-1:0]    r_data [2];
    logic [4:0]           r_vd   [2];
    logic [NUM_BYTES-1:0] r_be   [2];

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_err;

    logic [NUM_BYTES-1:0] w_be;
    logic                 w_be_any;
    logic                 w_osize_bad;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head_vld;
    logic                 w_byp;
    logic [1:0]           w_slot_vld;

    // ------------------------------------------------------------------
    // Byte-enable generation
    // ------------------------------------------------------------------
    assign w_osize_bad = (in_osize > 3'd4);

    // Byte b belongs to element (b >> osize). It is written when that element
    // lies in [vstart, len).
    always_comb begin
        w_be = '0;
        if (!w_osize_bad) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if ((LEN_W'(b >> in_osize) >= in_vstart) &&
                    (LEN_W'(b >> in_osize) <  in_len)) begin
                    w_be[b] = 1'b1;
                end
            end
        end
    end

    assign w_be_any = |w_be;

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    assign in_ready   = (r_count < 2'd2);
    assign w_accept   = in_valid && in_ready;
    assign w_head_vld = (r_count != 2'd0);
    assign w_pop      = w_head_vld && wr_ready;

`ifdef RISCV_V_WB_BYPASS_EN
    // Forward straight to the write port when nothing is queued ahead.
    assign w_byp  = (r_count == 2'd0) && !flush && in_valid && w_be_any;
    // A bypassed item taken by the VRF in the same cycle is never stored.
    assign w_push = w_accept && w_be_any && !flush && !(w_byp && wr_ready);
`else
    assign w_byp  = 1'b0;
    // Empty masks are consumed without occupying a slot.
    assign w_push = w_accept && w_be_any && !flush;
`endif

    // ------------------------------------------------------------------
    // Pointer / count / error state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_err   <= 1'b0;
        end else begin
            // The error pulse reports the accept even when a flush drops it.
            r_err <= w_accept && w_osize_bad;
            if (flush) begin
                // A flush wins over push and pop. A pop in this cycle already
                // completed on the VRF side and is not repeated.
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) begin
                    r_wptr <= ~r_wptr;
                end
                if (w_pop) begin
                    r_rptr <= ~r_rptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wptr] <= in_data;
            r_vd[r_wptr]   <= in_vd;
            r_be[r_wptr]   <= w_be;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: derived only from registered state, so it changes at the
    // same edge as the storage and clears at once on reset.
    // ------------------------------------------------------------------
    assign w_slot_vld[0] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_rptr == 1'b0));
    assign w_slot_vld[1] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_rptr == 1'b1));

    always_comb begin
        pending_vd = '0;
        if (w_slot_vld[0]) begin
            pending_vd = pending_vd | (32'd1 << r_vd[0]);
        end
        if (w_slot_vld[1]) begin
            pending_vd = pending_vd | (32'd1 << r_vd[1]);
        end
    end

    // ------------------------------------------------------------------
    // Write port: the head entry, or the live input when bypassing. Fields
    // read zero while nothing is offered, including during reset.
    // ------------------------------------------------------------------
    always_comb begin
        wr_valid = w_head_vld;
        wr_vd    = '0;
        wr_data  = '0;
        wr_be    = '0;
        if (w_head_vld) begin
            wr_vd   = r_vd[r_rptr];
            wr_data = r_data[r_rptr];
            wr_be   = r_be[r_rptr];
        end else if (w_byp) begin
            wr_valid = 1'b1;
            wr_vd    = in_vd;
            wr_data  = in_data;
            wr_be    = w_be;
        end
    end

    assign err_osize = r_err;

endmodule

// File: tb/tb_riscv_v_writeback_element.sv
module tb_riscv_v_writeback_element;

    localparam int DATA_W    = 128;
    localparam int NUM_BYTES = 16;
    localparam int LEN_W     = 5;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    logic [4:0]           in_vd;
    logic [2:0]           in_osize;
    logic [LEN_W-1:0]     in_len;
    logic [LEN_W-1:0]     in_vstart;
    logic                 flush;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [4:0]           wr_vd;
    logic [DATA_W-1:0]    wr_data;
    logic [NUM_BYTES-1:0] wr_be;
    logic [31:0]          pending_vd;
    logic                 err_osize;

    int n_cmp  = 0;
    int n_fail = 0;

    riscv_v_writeback_element #(
        .DATA_W    (DATA_W),
        .NUM_BYTES (NUM_BYTES),
        .LEN_W     (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_vd      (in_vd),
        .in_osize   (in_osize),
        .in_len     (in_len),
        .in_vstart  (in_vstart),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_vd      (wr_vd),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .pending_vd (pending_vd),
        .err_osize  (err_osize)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  vd;
        logic [2:0]  osize;
        logic [4:0]  len;
        logic [4:0]  vstart;
        logic [15:0] exp_be;
        logic        exp_err;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] vd, input logic [2:0] os, input logic [4:0] len,
                         input logic [4:0] vs, input logic [127:0] d);
        in_valid  = 1'b1;
        in_vd     = vd;
        in_osize  = os;
        in_len    = len;
        in_vstart = vs;
        in_data   = d;
    endtask

    initial begin
        // osize, len, vstart -> expected byte enables (16 bytes)
        vt[0]  = '{vd: 5'd5,  osize: 3'd2, len: 5'd3,  vstart: 5'd1, exp_be: 16'h0FF0, exp_err: 1'b0};
        vt[1]  = '{vd: 5'd6,  osize: 3'd0, len: 5'd4,  vstart: 5'd4, exp_be: 16'h0000, exp_err: 1'b0};
        vt[2]  = '{vd: 5'd2,  osize: 3'd6, len: 5'd16, vstart: 5'd0, exp_be: 16'h0000, exp_err: 1'b1};
        vt[3]  = '{vd: 5'd31, osize: 3'd0, len: 5'd16, vstart: 5'd0, exp_be: 16'hFFFF, exp_err: 1'b0};
        vt[4]  = '{vd: 5'd0,  osize: 3'd1, len: 5'd5,  vstart: 5'd2, exp_be: 16'h03F0, exp_err: 1'b0};
        vt[5]  = '{vd: 5'd12, osize: 3'd3, len: 5'd2,  vstart: 5'd1, exp_be: 16'hFF00, exp_err: 1'b0};
        vt[6]  = '{vd: 5'd7,  osize: 3'd4, len: 5'd1,  vstart: 5'd0, exp_be: 16'hFFFF, exp_err: 1'b0};
        vt[7]  = '{vd: 5'd3,  osize: 3'd4, len: 5'd1,  vstart: 5'd1, exp_be: 16'h0000, exp_err: 1'b0};
        vt[8]  = '{vd: 5'd9,  osize: 3'd0, len: 5'd3,  vstart: 5'd0, exp_be: 16'h0007, exp_err: 1'b0};
        vt[9]  = '{vd: 5'd20, osize: 3'd2, len: 5'd16, vstart: 5'd3, exp_be: 16'hF000, exp_err: 1'b0};
        vt[10] = '{vd: 5'd4,  osize: 3'd7, len: 5'd16, vstart: 5'd0, exp_be: 16'h0000, exp_err: 1'b1};
        vt[11] = '{vd: 5'd8,  osize: 3'd0, len: 5'd0,  vstart: 5'd0, exp_be: 16'h0000, exp_err: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_vd     = '0;
        in_osize  = '0;
        in_len    = '0;
        in_vstart = '0;
        flush     = 1'b0;
        wr_ready  = 1'b1;

        // Reset state
        step();
        step();
        check("rst_wr_valid", wr_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pending", pending_vd, 0);
        check("rst_err", err_osize, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_be", wr_be, 0);
        rst_n = 1'b1;
        step();

`ifndef RISCV_V_WB_BYPASS_EN
        // Table: one item each, always-ready VRF, 1-cycle latency
        for (int i = 0; i < 12; i++) begin
            logic [127:0] d;
            logic         wr_exp;
            d = {4{32'hA500_0000 + 32'(i)}};
            wr_exp = (vt[i].exp_be != 16'h0);
            drive(vt[i].vd, vt[i].osize, vt[i].len, vt[i].vstart, d);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_wr_valid", i), wr_valid, wr_exp);
            check($sformatf("v%0d_pending", i), pending_vd, wr_exp ? (32'd1 << vt[i].vd) : 32'd0);
            check($sformatf("v%0d_err", i), err_osize, vt[i].exp_err);
            if (wr_exp) begin
                check($sformatf("v%0d_wr_be", i), wr_be, vt[i].exp_be);
                check($sformatf("v%0d_wr_vd", i), wr_vd, vt[i].vd);
                check($sformatf("v%0d_wr_data", i), wr_data, d);
            end
            step();
            check($sformatf("v%0d_drain_valid", i), wr_valid, 0);
            check($sformatf("v%0d_drain_pending", i), pending_vd, 0);
            check($sformatf("v%0d_err_clear", i), err_osize, 0);
        end

        // Backpressure: two entries to the same vd
        wr_ready = 1'b0;
        drive(5'd1, 3'd0, 5'd16, 5'd0, 128'h1111);
        step();
        check("bp_ready_after1", in_ready, 1);
        check("bp_pending_after1", pending_vd, 32'h2);
        drive(5'd1, 3'd0, 5'd16, 5'd0, 128'h2222);
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_full_pending", pending_vd, 32'h2);
        check("bp_head_data", wr_data, 128'h1111);
        // Offered while full: must not be accepted
        drive(5'd14, 3'd0, 5'd16, 5'd0, 128'h3333);
        step();
        in_valid = 1'b0;
        check("bp_stall_data", wr_data, 128'h1111);
        check("bp_stall_valid", wr_valid, 1);
        check("bp_stall_ready", in_ready, 0);
        wr_ready = 1'b1;
        step();
        check("bp_second_data", wr_data, 128'h2222);
        check("bp_second_vd", wr_vd, 5'd1);
        check("bp_second_pending", pending_vd, 32'h2);
        check("bp_reopen_ready", in_ready, 1);
        step();
        check("bp_done_valid", wr_valid, 0);
        check("bp_done_pending", pending_vd, 0);

        // Streaming push+pop every cycle, pointers wrap
        for (int k = 0; k < 3; k++) begin
            drive(5'(10 + k), 3'd0, 5'd16, 5'd0, 128'(32'hC0DE_0000 + k));
            step();
            check($sformatf("st%0d_valid", k), wr_valid, 1);
            check($sformatf("st%0d_data", k), wr_data, 128'(32'hC0DE_0000 + k));
            check($sformatf("st%0d_pending", k), pending_vd, 32'd1 << (10 + k));
        end
        in_valid = 1'b0;
        step();
        check("st_drain_valid", wr_valid, 0);

        // Flush with two buffered entries and an offered item
        wr_ready = 1'b0;
        drive(5'd2, 3'd0, 5'd16, 5'd0, 128'hAA);
        step();
        drive(5'd3, 3'd0, 5'd16, 5'd0, 128'hBB);
        step();
        check("fl_full_pending", pending_vd, 32'h0000_000C);
        drive(5'd4, 3'd0, 5'd16, 5'd0, 128'hCC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", wr_valid, 0);
        check("fl_pending", pending_vd, 0);
        check("fl_ready", in_ready, 1);

        // Flush with one entry and a simultaneously accepted item
        drive(5'd6, 3'd0, 5'd16, 5'd0, 128'hDD);
        step();
        drive(5'd8, 3'd0, 5'd16, 5'd0, 128'hEE);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl1_valid", wr_valid, 0);
        check("fl1_pending", pending_vd, 0);
        step();
        check("fl1_no_late_write", wr_valid, 0);

        // Illegal osize accepted during a flush still reports
        drive(5'd8, 3'd5, 5'd16, 5'd0, 128'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_err_pulse", err_osize, 1);
        step();
        check("fl_err_clear", err_osize, 0);

        // Reset while an entry is stalled
        drive(5'd9, 3'd0, 5'd16, 5'd0, 128'h99);
        step();
        in_valid = 1'b0;
        check("rm_before_valid", wr_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rm_valid", wr_valid, 0);
        check("rm_pending", pending_vd, 0);
        check("rm_ready", in_ready, 1);
        check("rm_data", wr_data, 0);
        step();
        rst_n = 1'b1;
        wr_ready = 1'b1;
        step();
        check("rm_after_ready", in_ready, 1);
        check("rm_after_valid", wr_valid, 0);
`else
        // Same-cycle forward on an empty buffer with a ready VRF
        wr_ready = 1'b1;
        drive(5'd7, 3'd4, 5'd1, 5'd0, 128'h77);
        #1;
        check("byp_valid", wr_valid, 1);
        check("byp_be", wr_be, 16'hFFFF);
        check("byp_vd", wr_vd, 5'd7);
        check("byp_data", wr_data, 128'h77);
        check("byp_pending", pending_vd, 0);
        step();
        in_valid = 1'b0;
        #1;
        check("byp_after_valid", wr_valid, 0);
        check("byp_after_pending", pending_vd, 0);
        // Stalled VRF: forwarded and also stored
        wr_ready = 1'b0;
        drive(5'd3, 3'd0, 5'd16, 5'd0, 128'h33);
        #1;
        check("byp_stall_valid", wr_valid, 1);
        step();
        in_valid = 1'b0;
        check("byp_stored_valid", wr_valid, 1);
        check("byp_stored_pending", pending_vd, 32'h8);
        check("byp_stored_data", wr_data, 128'h33);
        wr_ready = 1'b1;
        step();
        check("byp_drain_valid", wr_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
